multicycle_controlunit: RTL and testbench

- Multi-cycle successor to the single-cycle main decoder: a state machine that sequences one RV32I instruction over several cycles.
- Drives the shared datapath: PC, IR, memory port, ALU muxes and register-file write.
- Covers R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI and AUIPC.
- Adds a memory ready/timeout handshake, a sticky fault flag and a retired-instruction counter.

---
 rtl/multicycle_controlunit_if.sv | 28 ++
 rtl/multicycle_controlunit.sv | 172 +++++++++++++++++
 tb/tb_multicycle_controlunit.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controlunit_if.sv
// Control bundle between the multi-cycle control unit (master) and the shared datapath (slave).
interface multicycle_controlunit_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       br_taken;
  logic       pc_write;
  logic       ir_write;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;

  modport master (
    input  opcode, mem_ready, br_taken,
    output pc_write, ir_write, mem_req, mem_we, iord, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src
  );

  modport slave (
    output opcode, mem_ready, br_taken,
    input  pc_write, ir_write, mem_req, mem_we, iord, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src
  );
endinterface

// File: rtl/multicycle_controlunit.sv
// Multi-cycle RV32I control unit with memory timeout, sticky fault and retire counter.
// Define ILLEGAL_TRAP_EN to fault on unknown opcodes instead of skipping them as NOPs.
module multicycle_controlunit #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned RETIRE_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_controlunit_if.master bus,
  output logic                     busy,
  output logic                     fault,
  output logic [RETIRE_W-1:0]      retired
);
  localparam int unsigned      CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_ADDR,
    S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR, S_FAULT
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  fault_q;
  logic [RETIRE_W-1:0]   retired_q;
  logic                  retire_c;

  // State register, wait counter, sticky fault and retire count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_d == S_FAULT) fault_q <= 1'b1;
      if (retire_c) retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  // Next-state and Moore decode; memory states also watch mem_ready
  always_comb begin
    state_d        = state_q;
    cnt_d          = '0;
    retire_c       = 1'b0;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.iord       = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.result_src = 2'b00;
    busy           = (state_q != S_FETCH);

    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = S_DECODE;
        end else if (cnt_q == CNT_LAST) state_d = S_FAULT;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_ADDR;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_FAULT;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R: begin
        bus.alu_op = 2'b10;
        state_d    = S_WB_ALU;
      end
      S_EXEC_I: begin
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 2'b11;
        state_d       = S_WB_ALU;
      end
      S_LUI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        state_d       = S_WB_ALU;
      end
      S_AUIPC: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        state_d       = S_WB_ALU;
      end
      S_ADDR: begin
        bus.alu_src_b = 2'b01;
        state_d       = (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) state_d = S_WB_MEM;
        else if (cnt_q == CNT_LAST) state_d = S_FAULT;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      S_MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end else if (cnt_q == CNT_LAST) state_d = S_FAULT;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      S_WB_ALU: begin
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
        retire_c      = 1'b1;
      end
      S_WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.result_src = 2'b01;
        state_d        = S_FETCH;
        retire_c       = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_op   = 2'b01;
        bus.pc_write = bus.br_taken;
        state_d      = S_FETCH;
        retire_c     = 1'b1;
      end
      S_JAL, S_JALR: begin
        bus.reg_write  = 1'b1;
        bus.result_src = 2'b10;
        bus.pc_write   = 1'b1;
        bus.alu_src_a  = (state_q == S_JAL) ? 2'b01 : 2'b00;
        bus.alu_src_b  = 2'b01;
        state_d        = S_FETCH;
        retire_c       = 1'b1;
      end
      S_FAULT: state_d = S_FAULT;
    endcase
  end

  assign fault   = fault_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_multicycle_controlunit.sv
// Scoreboard bench for multicycle_controlunit: per-cycle output and retire-count checks.
module tb_multicycle_controlunit;
  localparam int unsigned RW = 32;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b0000000;

  typedef enum int {
    T_RESET, T_FETCH, T_DECODE, T_EXEC_R, T_EXEC_I, T_LUI, T_AUIPC, T_ADDR,
    T_MEM_RD, T_MEM_WR, T_WB_ALU, T_WB_MEM, T_BRANCH, T_JAL, T_JALR, T_FAULT
  } tst_t;

  typedef struct {
    tst_t       st;
    logic [6:0] op;
    logic       rdy;
    logic       bt;
    logic       rst;
  } step_t;

  typedef struct packed {
    logic [15:0]   o;
    logic [RW-1:0] r;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          busy, fault;
  logic [RW-1:0] retired;

  int            errors = 0;
  int            checks = 0;
  logic [RW-1:0] model_ret = '0;
  step_t         seq[$];
  exp_t          sb[$];

  multicycle_controlunit_if bus();

  multicycle_controlunit #(.MEM_TIMEOUT(15), .RETIRE_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(tst_t st, logic [6:0] op, logic rdy, logic bt, logic rst);
    step_t s;
    s.st = st; s.op = op; s.rdy = rdy; s.bt = bt; s.rst = rst;
    return s;
  endfunction

  // Expected {pc_write,ir_write,mem_req,mem_we,iord,reg_write,a,b,op,rs,busy,fault}
  function automatic logic [15:0] exp_out(tst_t st, logic rdy, logic bt);
    logic pw, iw, rq, we, io, rw, bz, ft;
    logic [1:0] a, b, op, rs;
    {pw, iw, rq, we, io, rw, bz, ft} = '0;
    {a, b, op, rs} = '0;
    bz = 1'b1;
    case (st)
      T_FETCH:  begin rq = 1; a = 2'b01; b = 2'b10; pw = rdy; iw = rdy; bz = 0; end
      T_EXEC_R: op = 2'b10;
      T_EXEC_I: begin b = 2'b01; op = 2'b11; end
      T_LUI:    begin a = 2'b10; b = 2'b01; end
      T_AUIPC:  begin a = 2'b01; b = 2'b01; end
      T_ADDR:   b = 2'b01;
      T_MEM_RD: begin rq = 1; io = 1; end
      T_MEM_WR: begin rq = 1; we = 1; io = 1; end
      T_WB_ALU: rw = 1;
      T_WB_MEM: begin rw = 1; rs = 2'b01; end
      T_BRANCH: begin op = 2'b01; pw = bt; end
      T_JAL:    begin rw = 1; rs = 2'b10; pw = 1; a = 2'b01; b = 2'b01; end
      T_JALR:   begin rw = 1; rs = 2'b10; pw = 1; b = 2'b01; end
      T_FAULT:  ft = 1;
      default:  ;
    endcase
    return {pw, iw, rq, we, io, rw, a, b, op, rs, bz, ft};
  endfunction

  function automatic bit retiring(step_t s);
    case (s.st)
      T_WB_ALU, T_WB_MEM, T_BRANCH, T_JAL, T_JALR: return 1'b1;
      T_MEM_WR: return s.rdy;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] outs_vec();
    return {bus.pc_write, bus.ir_write, bus.mem_req, bus.mem_we, bus.iord, bus.reg_write,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src, busy, fault};
  endfunction

  // Drive one cycle of stimulus and queue what the DUT should show for it
  task automatic drive_step(step_t s);
    exp_t e;
    @(negedge clk);
    rst_n         = s.rst;
    bus.opcode    = s.op;
    bus.mem_ready = s.rdy;
    bus.br_taken  = s.bt;
    e.o = exp_out(s.st, s.rdy, s.bt);
    e.r = model_ret;
    sb.push_back(e);
    if (!s.rst) model_ret = '0;
    else if (retiring(s)) model_ret = model_ret + RW'(1);
    #2;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; bus.opcode = '0; bus.mem_ready = 1'b0; bus.br_taken = 1'b0;
    repeat (2) @(posedge clk);
    seq.delete();
    seq.push_back(mk(T_RESET, OP_R, 0, 0, 0));
    seq.push_back(mk(T_RESET, OP_R, 0, 0, 1));
    foreach (seq[i]) begin
      drive_step(seq[i]);
      e = sb.pop_front();
      checks++;
      if (outs_vec() !== e.o) begin errors++; $display("FAIL reset step %0d %s outs got=%h exp=%h", i, seq[i].st.name(), outs_vec(), e.o); end
      checks++;
      if (retired !== e.r) begin errors++; $display("FAIL reset step %0d retired got=%0d exp=%0d", i, retired, e.r); end
    end
  endtask

  task automatic test_r_type();
    exp_t e;
    seq.delete();
    seq.push_back(mk(T_FETCH,  OP_R, 1, 0, 1));
    seq.push_back(mk(T_DECODE, OP_R, 0, 0, 1));
    seq.push_back(mk(T_EXEC_R, OP_R, 0, 0, 1));
    seq.push_back(mk(T_WB_ALU, OP_R, 0, 0, 1));
    seq.push_back(mk(T_FETCH,  OP_R, 0, 0, 1));
    foreach (seq[i]) begin
      drive_step(seq[i]);
      e = sb.pop_front();
      checks++;
      if (outs_vec() !== e.o) begin errors++; $display("FAIL r_type step %0d %s outs got=%h exp=%h", i, seq[i].st.name(), outs_vec(), e.o); end
      checks++;
      if (retired !== e.r) begin errors++; $display("FAIL r_type step %0d retired got=%0d exp=%0d", i, retired, e.r); end
    end
  endtask

  task automatic test_load_wait();
    exp_t e;
    seq.delete();
    seq.push_back(mk(T_FETCH,  OP_LOAD, 1, 0, 1));
    seq.push_back(mk(T_DECODE, OP_LOAD, 0, 0, 1));
    seq.push_back(mk(T_ADDR,   OP_LOAD, 0, 0, 1));
    for (int k = 0; k < 3; k++) seq.push_back(mk(T_MEM_RD, OP_LOAD, 0, 0, 1));
    seq.push_back(mk(T_MEM_RD, OP_LOAD, 1, 0, 1));
    seq.push_back(mk(T_WB_MEM, OP_LOAD, 0, 0, 1));
    seq.push_back(mk(T_FETCH,  OP_LOAD, 0, 0, 1));
    foreach (seq[i]) begin
      drive_step(seq[i]);
      e = sb.pop_front();
      checks++;
      if (outs_vec() !== e.o) begin errors++; $display("FAIL load_wait step %0d %s outs got=%h exp=%h", i, seq[i].st.name(), outs_vec(), e.o); end
      checks++;
      if (retired !== e.r) begin errors++; $display("FAIL load_wait step %0d retired got=%0d exp=%0d", i, retired, e.r); end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    seq.delete();
    seq.push_back(mk(T_FETCH,  OP_BR, 1, 0, 1));
    seq.push_back(mk(T_DECODE, OP_BR, 0, 0, 1));
    seq.push_back(mk(T_BRANCH, OP_BR, 0, 0, 1));
    seq.push_back(mk(T_FETCH,  OP_BR, 1, 1, 1));
    seq.push_back(mk(T_DECODE, OP_BR, 0, 1, 1));
    seq.push_back(mk(T_BRANCH, OP_BR, 0, 1, 1));
    seq.push_back(mk(T_FETCH,  OP_BR, 0, 0, 1));
    foreach (seq[i]) begin
      drive_step(seq[i]);
      e = sb.pop_front();
      checks++;
      if (outs_vec() !== e.o) begin errors++; $display("FAIL branch step %0d %s outs got=%h exp=%h", i, seq[i].st.name(), outs_vec(), e.o); end
      checks++;
      if (retired !== e.r) begin errors++; $display("FAIL branch step %0d retired got=%0d exp=%0d", i, retired, e.r); end
    end
  endtask

  task automatic test_other_types();
    exp_t e;
    seq.delete();
    seq.push_back(mk(T_FETCH,  OP_JAL,   1, 0, 1));
    seq.push_back(mk(T_DECODE, OP_JAL,   0, 0, 1));
    seq.push_back(mk(T_JAL,    OP_JAL,   0, 0, 1));
    seq.push_back(mk(T_FETCH,  OP_JALR,  1, 0, 1));
    seq.push_back(mk(T_DECODE, OP_JALR,  0, 0, 1));
    seq.push_back(mk(T_JALR,   OP_JALR,  0, 0, 1));
    seq.push_back(mk(T_FETCH,  OP_LUI,   1, 0, 1));
    seq.push_back(mk(T_DECODE, OP_LUI,   0, 0, 1));
    seq.push_back(mk(T_LUI,    OP_LUI,   0, 0, 1));
    seq.push_back(mk(T_WB_ALU, OP_LUI,   0, 0, 1));
    seq.push_back(mk(T_FETCH,  OP_AUIPC, 1, 0, 1));
    seq.push_back(mk(T_DECODE, OP_AUIPC, 0, 0, 1));
    seq.push_back(mk(T_AUIPC,  OP_AUIPC, 0, 0, 1));
    seq.push_back(mk(T_WB_ALU, OP_AUIPC, 0, 0, 1));
    seq.push_back(mk(T_FETCH,  OP_I,     1, 0, 1));
    seq.push_back(mk(T_DECODE, OP_I,     0, 0, 1));
    seq.push_back(mk(T_EXEC_I, OP_I,     0, 0, 1));
    seq.push_back(mk(T_WB_ALU, OP_I,     0, 0, 1));
    seq.push_back(mk(T_FETCH,  OP_STORE, 1, 0, 1));
    seq.push_back(mk(T_DECODE, OP_STORE, 0, 0, 1));
    seq.push_back(mk(T_ADDR,   OP_STORE, 0, 0, 1));
    seq.push_back(mk(T_MEM_WR, OP_STORE, 0, 0, 1));
    seq.push_back(mk(T_MEM_WR, OP_STORE, 1, 0, 1));
    seq.push_back(mk(T_FETCH,  OP_STORE, 0, 0, 1));
    foreach (seq[i]) begin
      drive_step(seq[i]);
      e = sb.pop_front();
      checks++;
      if (outs_vec() !== e.o) begin errors++; $display("FAIL other_types step %0d %s outs got=%h exp=%h", i, seq[i].st.name(), outs_vec(), e.o); end
      checks++;
      if (retired !== e.r) begin errors++; $display("FAIL other_types step %0d retired got=%0d exp=%0d", i, retired, e.r); end
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    seq.delete();
    seq.push_back(mk(T_FETCH,  OP_BAD, 1, 0, 1));
    seq.push_back(mk(T_DECODE, OP_BAD, 0, 0, 1));
`ifdef ILLEGAL_TRAP_EN
    seq.push_back(mk(T_FAULT,  OP_BAD, 1, 0, 1));
    seq.push_back(mk(T_FAULT,  OP_BAD, 0, 0, 0));
    seq.push_back(mk(T_RESET,  OP_BAD, 0, 0, 1));
`else
    seq.push_back(mk(T_FETCH,  OP_BAD, 0, 0, 1));
`endif
    foreach (seq[i]) begin
      drive_step(seq[i]);
      e = sb.pop_front();
      checks++;
      if (outs_vec() !== e.o) begin errors++; $display("FAIL illegal step %0d %s outs got=%h exp=%h", i, seq[i].st.name(), outs_vec(), e.o); end
      checks++;
      if (retired !== e.r) begin errors++; $display("FAIL illegal step %0d retired got=%0d exp=%0d", i, retired, e.r); end
    end
  endtask

  task automatic test_store_abort();
    exp_t e;
    seq.delete();
    seq.push_back(mk(T_FETCH,  OP_STORE, 1, 0, 1));
    seq.push_back(mk(T_DECODE, OP_STORE, 0, 0, 1));
    seq.push_back(mk(T_ADDR,   OP_STORE, 0, 0, 1));
    seq.push_back(mk(T_MEM_WR, OP_STORE, 0, 0, 0));
    seq.push_back(mk(T_RESET,  OP_STORE, 1, 0, 1));
    seq.push_back(mk(T_FETCH,  OP_R,     1, 0, 1));
    seq.push_back(mk(T_DECODE, OP_R,     0, 0, 1));
    seq.push_back(mk(T_EXEC_R, OP_R,     0, 0, 1));
    seq.push_back(mk(T_WB_ALU, OP_R,     0, 0, 1));
    seq.push_back(mk(T_FETCH,  OP_R,     0, 0, 1));
    foreach (seq[i]) begin
      drive_step(seq[i]);
      e = sb.pop_front();
      checks++;
      if (outs_vec() !== e.o) begin errors++; $display("FAIL store_abort step %0d %s outs got=%h exp=%h", i, seq[i].st.name(), outs_vec(), e.o); end
      checks++;
      if (retired !== e.r) begin errors++; $display("FAIL store_abort step %0d retired got=%0d exp=%0d", i, retired, e.r); end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    seq.delete();
    seq.push_back(mk(T_FETCH, OP_R, 0, 0, 0));
    seq.push_back(mk(T_RESET, OP_R, 0, 0, 1));
    // ready arriving on the last allowed cycle still wins
    for (int k = 0; k < 14; k++) seq.push_back(mk(T_FETCH, OP_R, 0, 0, 1));
    seq.push_back(mk(T_FETCH,  OP_R, 1, 0, 1));
    seq.push_back(mk(T_DECODE, OP_R, 0, 0, 1));
    seq.push_back(mk(T_EXEC_R, OP_R, 0, 0, 1));
    seq.push_back(mk(T_WB_ALU, OP_R, 0, 0, 1));
    for (int k = 0; k < 15; k++) seq.push_back(mk(T_FETCH, OP_R, 0, 0, 1));
    for (int k = 0; k < 3; k++) seq.push_back(mk(T_FAULT, OP_R, 1, 0, 1));
    seq.push_back(mk(T_FAULT,  OP_R, 0, 0, 0));
    seq.push_back(mk(T_RESET,  OP_R, 0, 0, 1));
    seq.push_back(mk(T_FETCH,  OP_R, 1, 0, 1));
    seq.push_back(mk(T_DECODE, OP_R, 0, 0, 1));
    seq.push_back(mk(T_EXEC_R, OP_R, 0, 0, 1));
    seq.push_back(mk(T_WB_ALU, OP_R, 0, 0, 1));
    seq.push_back(mk(T_FETCH,  OP_R, 0, 0, 1));
    foreach (seq[i]) begin
      drive_step(seq[i]);
      e = sb.pop_front();
      checks++;
      if (outs_vec() !== e.o) begin errors++; $display("FAIL timeout step %0d %s outs got=%h exp=%h", i, seq[i].st.name(), outs_vec(), e.o); end
      checks++;
      if (retired !== e.r) begin errors++; $display("FAIL timeout step %0d retired got=%0d exp=%0d", i, retired, e.r); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_r_type();
    test_load_wait();
    test_branch();
    test_other_types();
    test_illegal();
    test_store_abort();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
